alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/alu_func_core.sv | 57 +++++
 rtl/alu_issue_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and default latencies for the
// ALU issue arbiter and its function core.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam int unsigned LAT_LOGIC_DEF = 1;
    localparam int unsigned LAT_ADD_DEF   = 2;
    localparam int unsigned LAT_LONG_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Illegal opcodes complete on the logic-class latency.
    function automatic int unsigned op_latency(input logic [2:0] op,
                                               input int unsigned lat_logic,
                                               input int unsigned lat_add,
                                               input int unsigned lat_long);
        case (op)
            OP_ADD:                 return lat_add;
            OP_MUL, OP_SHL, OP_SHR: return lat_long;
            default:                return lat_logic;
        endcase
    endfunction

endpackage

// File: rtl/alu_func_core.sv
// Purely combinational 8-bit ALU: forward, add, and, or, multiply and the
// fill-selectable shifts; flags the one illegal opcode.
module alu_func_core
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] OP,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] RESULT,
    output logic       ERR
);

    logic [3:0] amt;
    logic       fill_l;
    logic       fill_r;
    logic [7:0] shl_rot;
    logic [7:0] shl;
    logic [7:0] shr;

    assign amt     = B[3:0];
    assign fill_l  = (B[7:6] == 2'b01) & A[0];
    assign fill_r  = B[7] & A[7];
    // Low byte of {A,A} shifted right by 8-r is A rotated left by r.
    assign shl_rot = 8'({A, A} >> (4'd8 - {1'b0, amt[2:0]}));

    always_comb begin
        if (B[7:6] == 2'b10) begin
            shl = shl_rot;
        end else if (amt[3]) begin
            shl = {8{fill_l}};
        end else begin
            shl = (A << amt[2:0]) | ({8{fill_l}} & ~(8'hFF << amt[2:0]));
        end

        if (amt[3]) begin
            shr = {8{fill_r}};
        end else begin
            shr = (A >> amt[2:0]) | ({8{fill_r}} & ~(8'hFF >> amt[2:0]));
        end
    end

    always_comb begin
        RESULT = 8'h00;
        ERR    = 1'b0;
        case (OP)
            OP_FWD:  RESULT = A;
            OP_ADD:  RESULT = A + B;
            OP_AND:  RESULT = A & B;
            OP_OR:   RESULT = A | B;
            OP_MUL:  RESULT = A * B;
            OP_SHL:  RESULT = shl;
            OP_SHR:  RESULT = shr;
            default: ERR    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue front end for a single-op-in-flight ALU with
// per-opcode latency and a held response until the consumer takes it.
module alu_issue_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned LAT_LOGIC = LAT_LOGIC_DEF,
    parameter int unsigned LAT_ADD   = LAT_ADD_DEF,
    parameter int unsigned LAT_LONG  = LAT_LONG_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [2:0] REQ0_OP,
    input  logic [7:0] REQ0_A,
    input  logic [7:0] REQ0_B,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [2:0] REQ1_OP,
    input  logic [7:0] REQ1_A,
    input  logic [7:0] REQ1_B,
    output logic       RESP_VALID,
    input  logic       RESP_READY,
    output logic       RESP_ID,
    output logic [7:0] RESP_DATA,
    output logic       RESP_ZERO,
    output logic       RESP_ERR
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        id_q;
    logic [7:0]  data_q;
    logic        zero_q;
    logic        err_q;

    logic        grant_id;
    logic        accept;
    logic [2:0]  sel_op;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [7:0]  core_result;
    logic        core_err;
    int unsigned lat;

    // Contention goes to the pointer; a lone requester always wins.
    assign grant_id = (REQ0_VALID & REQ1_VALID) ? ptr_q : REQ1_VALID;
    assign accept   = (state_q == IDLE) & (REQ0_VALID | REQ1_VALID) & ~RESET;

    assign REQ0_READY = accept & ~grant_id;
    assign REQ1_READY = accept & grant_id;

    assign sel_op = grant_id ? REQ1_OP : REQ0_OP;
    assign sel_a  = grant_id ? REQ1_A  : REQ0_A;
    assign sel_b  = grant_id ? REQ1_B  : REQ0_B;
    assign lat    = op_latency(sel_op, LAT_LOGIC, LAT_ADD, LAT_LONG);

    alu_func_core u_core (
        .OP     (sel_op),
        .A      (sel_a),
        .B      (sel_b),
        .RESULT (core_result),
        .ERR    (core_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = accept ? ~grant_id : ptr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lat <= 1) begin
                        state_d = DONE;
                    end else begin
                        // Counter holds the BUSY cycles remaining beyond the first.
                        state_d = BUSY;
                        cnt_d   = 2'(lat - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                if (RESP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= 8'h00;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                id_q   <= grant_id;
                data_q <= core_result;
                zero_q <= (core_result == 8'h00);
                err_q  <= core_err;
            end
        end
    end

    assign RESP_VALID = (state_q == DONE);
    assign RESP_ID    = id_q;
    assign RESP_DATA  = data_q;
    assign RESP_ZERO  = zero_q;
    assign RESP_ERR   = err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_alu_issue_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic       REQ0_READY, REQ1_READY;
    logic [2:0] REQ0_OP = 3'd0, REQ1_OP = 3'd0;
    logic [7:0] REQ0_A = 8'd0, REQ0_B = 8'd0, REQ1_A = 8'd0, REQ1_B = 8'd0;
    logic       RESP_VALID, RESP_READY = 1'b0;
    logic       RESP_ID, RESP_ZERO, RESP_ERR;
    logic [7:0] RESP_DATA;

    alu_issue_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_OP    (REQ0_OP),
        .REQ0_A     (REQ0_A),
        .REQ0_B     (REQ0_B),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_OP    (REQ1_OP),
        .REQ1_A     (REQ1_A),
        .REQ1_B     (REQ1_B),
        .RESP_VALID (RESP_VALID),
        .RESP_READY (RESP_READY),
        .RESP_ID    (RESP_ID),
        .RESP_DATA  (RESP_DATA),
        .RESP_ZERO  (RESP_ZERO),
        .RESP_ERR   (RESP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       zero;
        logic       err;
    } resp_t;

    typedef struct {
        resp_t       r;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          inflight = 1'b0;
    int unsigned resp_at = 0;
    bit          ptr = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Shifts modelled one bit position at a time.
    function automatic logic [7:0] ref_shl(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin
            case (b[7:6])
                2'b10:   r = {r[6:0], r[7]};
                2'b01:   r = {r[6:0], a[0]};
                default: r = {r[6:0], 1'b0};
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_shr(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = a;
        logic       f = b[7] & a[7];
        for (int i = 0; i < int'(b[3:0]); i++) r = {f, r[7:1]};
        return r;
    endfunction

    function automatic resp_t ref_resp(input logic id, input logic [2:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
        resp_t r;
        r.id  = id;
        r.err = 1'b0;
        case (op)
            3'd0: r.data = a;
            3'd1: r.data = 8'((int'(a) + int'(b)) % 256);
            3'd2: r.data = a & b;
            3'd3: r.data = a | b;
            3'd4: r.data = 8'((int'(a) * int'(b)) % 256);
            3'd5: r.data = ref_shl(a, b);
            3'd6: r.data = ref_shr(a, b);
            default: begin
                r.data = 8'h00;
                r.err  = 1'b1;
            end
        endcase
        r.zero = (r.data == 8'h00);
        return r;
    endfunction

    function automatic int unsigned ref_lat(input logic [2:0] op);
        if (op == 3'd1) return 2;
        if (op == 3'd4 || op == 3'd5 || op == 3'd6) return 3;
        return 1;
    endfunction

    // One clock cycle of stimulus; the model predicts the grant and in-flight state.
    task automatic step(input bit v0, input logic [2:0] op0, input logic [7:0] a0,
                        input logic [7:0] b0, input bit v1, input logic [2:0] op1,
                        input logic [7:0] a1, input logic [7:0] b1, input bit rr);
        bit   acc;
        logic g;
        @(negedge CLK);
        REQ0_VALID = v0; REQ0_OP = op0; REQ0_A = a0; REQ0_B = b0;
        REQ1_VALID = v1; REQ1_OP = op1; REQ1_A = a1; REQ1_B = b1;
        RESP_READY = rr;
        #2;
        acc = !inflight && (v0 || v1);
        g   = (v0 && v1) ? ptr : v1;
        check("req0_ready", 32'(REQ0_READY), 32'(acc && !g));
        check("req1_ready", 32'(REQ1_READY), 32'(acc && g));
        if (acc) begin
            exp_t e;
            e.r   = g ? ref_resp(1'b1, op1, a1, b1) : ref_resp(1'b0, op0, a0, b0);
            e.due = cyc + (g ? ref_lat(op1) : ref_lat(op0));
            sb.push_back(e);
            resp_at  = e.due;
            inflight = 1'b1;
            ptr      = !g;
        end else if (inflight && cyc >= resp_at && rr) begin
            inflight = 1'b0;
        end
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, rr);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && inflight; i++) idle(1'b1);
        check("drain_done", 32'(inflight), 32'd0);
    endtask

    task automatic op0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        step(1'b1, op, a, b, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
        drain();
    endtask

    task automatic op1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, op, a, b, 1'b1);
        drain();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        RESET = 1'b1;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; RESP_READY = 1'b0;
        #2;
        check("ready_in_reset", 32'({REQ0_READY, REQ1_READY}), 32'd0);
        check("resp_in_reset",
              32'({RESP_VALID, RESP_ID, RESP_DATA, RESP_ZERO, RESP_ERR}), 32'd0);
        sb.delete();
        inflight = 1'b0;
        ptr      = 1'b0;
        repeat (cycles) @(negedge CLK);
        RESET = 1'b0;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    // Monitor: pops an expectation when a response appears, then holds it until taken.
    initial begin
        exp_t cur;
        bit   active = 1'b0;
        forever begin
            @(negedge CLK);
            #3;
            if (RESET) begin
                active = 1'b0;
            end else if (RESP_VALID) begin
                if (!active) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL resp_unexpected: got data 0x%0h, expected no response",
                                 RESP_DATA);
                    end else begin
                        cur = sb.pop_front();
                        check("resp_latency", cyc, cur.due);
                        active = 1'b1;
                    end
                end
                if (active) begin
                    check("resp_fields", 32'({RESP_ID, RESP_DATA, RESP_ZERO, RESP_ERR}),
                          32'(cur.r));
                    if (RESP_READY) active = 1'b0;
                end
            end else if (active) begin
                n_checks++;
                $display("FAIL resp_dropped: got RESP_VALID 0, expected 1 until consumed");
                active = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(2);

        op0(3'd1, 8'h7F, 8'h02);                  // ADD -> 0x81 after 2 edges

        do_reset(1);                              // pointer back to requester 0
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd0, 8'h11, 8'h00, 1'b1, 3'd0, 8'h22, 8'h00, 1'b1);
        drain();

        op1(3'd4, 8'h10, 8'h11);                  // MUL -> 0x10, id 1

        op0(3'd5, 8'h81, 8'h01);
        op0(3'd5, 8'h81, 8'h41);
        op0(3'd5, 8'h81, 8'h81);
        op0(3'd5, 8'h81, 8'h08);
        op0(3'd6, 8'h80, 8'h83);

        step(1'b1, 3'd2, 8'hF0, 8'h0F, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd0, 8'h55, 8'h00, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        idle(1'b1);
        op0(3'd0, 8'h55, 8'h00);

        step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 3'd4, 8'h07, 8'h09, 1'b1);
        idle(1'b1);
        do_reset(2);                              // discards the in-flight MUL
        op1(3'd7, 8'hAB, 8'hCD);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();
        repeat (3) idle(1'b1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
